// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types and constants for the common data bus (CDB) arbiter slice.
//   CDB_packet_t   : one functional-unit result as broadcast on the CDB
//   N_CDB_SRC      : default number of result sources feeding the CDB
//   CDB_FIFO_DEPTH : default entries buffered per source
//   CDB_IDLE       : value the CDB carries when nothing is broadcast
//   isValidTag()   : ROB entry 0 is reserved as "no tag"
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

   localparam int N_CDB_SRC      = 4;
   localparam int CDB_FIFO_DEPTH = 2;

   typedef struct packed {
      logic [3:0]  dest_ROB_entry;
      logic [31:0] result;
      logic        load_step1;
   } CDB_packet_t;

   localparam CDB_packet_t CDB_IDLE = '0;

   // A packet is only worth broadcasting when it names a real ROB entry;
   // entry 0 doubles as the idle tag so consumers never match on it.
   function automatic logic isValidTag(input CDB_packet_t pkt);
      return pkt.dest_ROB_entry != 4'd0;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// ---------------------------------------------------------------------------
// cdb_fifo
// Small in-order buffer holding results from one functional unit until the
// CDB arbiter grants that source.
//   clk      : clock
//   reset    : synchronous active-low reset
//   flush_i  : synchronous empty (branch mispredict)
//   push_i   : enqueue data_i (ignored when full)
//   data_i   : packet to enqueue
//   pop_i    : dequeue the head (ignored when empty)
//   head_o   : oldest buffered packet
//   count_o  : registered occupancy
//   full_o   : occupancy == DEPTH
//   empty_o  : occupancy == 0
// ---------------------------------------------------------------------------
module cdb_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = CDB_FIFO_DEPTH,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             push_i,
   input  CDB_packet_t      data_i,
   input  logic             pop_i,
   output CDB_packet_t      head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   CDB_packet_t      mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush;
   logic             doPop;

   // Pointers wrap explicitly at DEPTH-1 so the buffer stays correct even if
   // the depth is ever changed to something that does not fill PTR_W bits.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rdPtr_q];
   assign doPush  = push_i & ~full_o;
   assign doPop   = pop_i & ~empty_o;

   // Next-state for pointers and occupancy. A push and pop in the same cycle
   // move both pointers and leave the count alone, so order is preserved.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) begin
         wrPtr_d = nextPtr(wrPtr_q);
      end
      if (doPop) begin
         rdPtr_d = nextPtr(rdPtr_q);
      end
      if (doPush && !doPop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!doPush && doPop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Control state. Reset and flush both simply forget every entry; the
   // storage itself is not cleared because nothing reads it while empty.
   always_ff @(posedge clk) begin
      if (!reset || flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Packet storage, written at the tail on every accepted push.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Collects results from N_SRC functional units into per-source FIFOs and
// broadcasts at most one per cycle on the CDB, chosen round-robin.
//   clk          : clock
//   reset        : synchronous active-low reset
//   mispredicted : flush every buffered and in-flight result
//   fu_valid     : per-source result offer
//   fu_packet    : per-source result
//   fu_ready     : per-source accept (from registered FIFO occupancy only)
//   CDB_out      : registered broadcast, idle (all zero) when nothing won
//   cdb_grant    : one-hot source of CDB_out, zero when idle
// ---------------------------------------------------------------------------
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_SRC = N_CDB_SRC,
   parameter int DEPTH = CDB_FIFO_DEPTH
)
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         mispredicted,
   input  logic        [N_SRC-1:0]      fu_valid,
   input  CDB_packet_t [N_SRC-1:0]      fu_packet,
   output logic        [N_SRC-1:0]      fu_ready,
   output CDB_packet_t                  CDB_out,
   output logic        [N_SRC-1:0]      cdb_grant
);

   localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int SUM_W = PTR_W + 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic        [N_SRC-1:0] push;
   logic        [N_SRC-1:0] pop;
   logic        [N_SRC-1:0] full;
   logic        [N_SRC-1:0] empty;
   CDB_packet_t [N_SRC-1:0] head;
   logic        [CNT_W-1:0] count [N_SRC];

   logic [PTR_W-1:0] ptr_q, ptr_d;
   CDB_packet_t      cdbOut_q, cdbOut_d;
   logic [N_SRC-1:0] grant_q, grant_d;
   logic             readyEn_q;

   logic             winnerValid;
   logic [PTR_W-1:0] winner;
   logic [SUM_W-1:0] probeSum;
   logic [PTR_W-1:0] probeIdx;

   // One FIFO per source. Readiness comes from the registered count plus a
   // registered "out of reset" flag, so a pop never ripples into fu_ready.
   // Tag-0 offers and offers during a flush are dropped without stalling.
   for (genvar g = 0; g < N_SRC; g++) begin : gSrc
      assign fu_ready[g] = readyEn_q & (count[g] < CNT_W'(DEPTH));
      assign push[g]     = fu_valid[g] & fu_ready[g] & ~full[g] & ~mispredicted
                           & isValidTag(fu_packet[g]);

      cdb_fifo #(.DEPTH(DEPTH)) uFifo (
         .clk     (clk),
         .reset   (reset),
         .flush_i (mispredicted),
         .push_i  (push[g]),
         .data_i  (fu_packet[g]),
         .pop_i   (pop[g]),
         .head_o  (head[g]),
         .count_o (count[g]),
         .full_o  (full[g]),
         .empty_o (empty[g])
      );
   end

   // Round-robin search: probe sources ptr, ptr+1, ... wrapping at N_SRC.
   // Walking the offsets from far to near lets the nearest non-empty source
   // overwrite any farther one, which keeps the loop free of early exits.
   always_comb begin
      winnerValid = 1'b0;
      winner      = '0;
      probeSum    = '0;
      probeIdx    = '0;
      for (int off = N_SRC - 1; off >= 0; off--) begin
         probeSum = {1'b0, ptr_q} + SUM_W'(off);
         if (probeSum >= SUM_W'(N_SRC)) begin
            probeSum = probeSum - SUM_W'(N_SRC);
         end
         probeIdx = probeSum[PTR_W-1:0];
         if (!empty[probeIdx]) begin
            winnerValid = 1'b1;
            winner      = probeIdx;
         end
      end
   end

   // Broadcast decision: pop the winner's head straight into the output
   // register and move the pointer just past it. A flush suppresses the
   // broadcast and returns the pointer to source 0.
   always_comb begin
      pop      = '0;
      grant_d  = '0;
      cdbOut_d = CDB_IDLE;
      ptr_d    = ptr_q;
      if (mispredicted) begin
         ptr_d = '0;
      end else if (winnerValid) begin
         pop[winner]     = 1'b1;
         grant_d[winner] = 1'b1;
         cdbOut_d        = head[winner];
         ptr_d           = (winner == PTR_W'(N_SRC - 1)) ? '0 : winner + PTR_W'(1);
      end
   end

   // Arbiter state and the CDB output register. Every broadcast lives for
   // exactly one cycle because the register reloads every edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q     <= '0;
         cdbOut_q  <= CDB_IDLE;
         grant_q   <= '0;
         readyEn_q <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         cdbOut_q  <= cdbOut_d;
         grant_q   <= grant_d;
         readyEn_q <= 1'b1;
      end
   end

   assign CDB_out   = cdbOut_q;
   assign cdb_grant = grant_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: N_SRC, 4, number of functional-unit result sources.
REQ-002 Parameter: DEPTH, 2, entries per source FIFO; SHALL be a power of 2.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled only on posedge clk.
REQ-005 Port: mispredicted  input  1  synchronous flush of all buffered and broadcast results.
REQ-006 Port: fu_valid  input  N_SRC  per-source result offer.
REQ-007 Port: fu_packet  input  N_SRC x CDB_packet_t  per-source result (dest_ROB_entry[3:0], result[31:0], load_step1).
REQ-008 Port: fu_ready  output  N_SRC  per-source accept; a transfer occurs when fu_valid[i] & fu_ready[i] at posedge.
REQ-009 Port: CDB_out  output  CDB_packet_t  registered broadcast to reservation stations, ROB, register status.
REQ-010 Port: cdb_grant  output  N_SRC  one-hot, registered; source index of the current CDB_out, all-zero when idle.

Function
REQ-011 Idle CDB SHALL be dest_ROB_entry=0, result=0, load_step1=0; ROB entry 0 is never a valid tag.
REQ-012 Each source SHALL own a DEPTH-entry FIFO (cdb_fifo) holding accepted packets in order.
REQ-013 fu_ready[i] SHALL equal (FIFO i count < DEPTH) from registered count only; no combinational path from pop to ready.
REQ-014 An offered packet with dest_ROB_entry==0 SHALL be discarded, not enqueued; fu_ready unaffected.
REQ-015 Each cycle the arbiter SHALL select exactly one non-empty FIFO, or none if all empty.
REQ-016 Selection SHALL be round-robin: search starts at priority pointer ptr, wraps modulo N_SRC.
REQ-017 On a grant to source k, ptr SHALL become (k+1) mod N_SRC; ptr unchanged when no grant.
REQ-018 Winner's head SHALL be popped and registered into CDB_out/cdb_grant at the same posedge.
REQ-019 With no winner, CDB_out SHALL be driven idle and cdb_grant=0 next cycle.
REQ-020 Latency: packet accepted at edge t SHALL appear on CDB_out no earlier than after edge t+1 (2 cycles from offer), immediately when uncontended.
REQ-021 Throughput: one broadcast per cycle; each CDB_out value SHALL be held exactly one cycle.
REQ-022 Simultaneous push and pop on one FIFO SHALL keep count unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-023 Starvation bound: a non-empty FIFO SHALL be granted within N_SRC cycles.
REQ-024 mispredicted at an edge SHALL empty all FIFOs, drive CDB_out idle, cdb_grant=0; offers in that cycle SHALL be dropped; ptr SHALL reset to 0.
REQ-025 load_step1 SHALL pass through unchanged; arbiter SHALL not interpret it.

Reset
REQ-026 reset low at posedge SHALL clear all FIFO counts/pointers, ptr=0, CDB_out idle, cdb_grant=0.
REQ-027 During reset fu_ready SHALL be 0; after reset release, fu_ready SHALL be all-ones the next cycle.
REQ-028 Reset mid-operation SHALL discard all buffered packets without broadcasting them; reset dominates mispredicted.

Structure
REQ-029 CDB_packet_t and constants N_CDB_SRC=4, CDB_FIFO_DEPTH=2 SHALL live in the shared structs package.
REQ-030 Per-source buffering SHALL be sub-module cdb_fifo (push, pop, head, count, full, empty, flush), instantiated N_SRC times.
REQ-031 Arbiter and output register SHALL reside in cdb_arbiter; no latches; one always_ff per state group.

Verification
REQ-032 Single source 2, ROB 5, result 0xDEADBEEF offered at cycle 1 -> CDB_out ROB 5/0xDEADBEEF during cycle 3 only, cdb_grant=4'b0100, idle afterwards.
REQ-033 All four sources offer ROB 1..4 same cycle, ptr=0 -> broadcasts ROB 1,2,3,4 in consecutive cycles; ptr ends 0.
REQ-034 Source 0 offers every cycle while CDB held busy by sources 1-3 -> fu_ready[0] drops after 2 accepts, rises when a pop occurs; order preserved, no loss.
REQ-035 Offer with dest_ROB_entry 0 -> never broadcast, FIFO count stays 0.
REQ-036 Three FIFOs non-empty, mispredicted pulsed one cycle -> next cycle CDB_out idle, all fu_ready=1, no stale ROB tags ever broadcast.
REQ-037 reset low for one cycle with packets buffered -> CDB_out idle, cdb_grant=0, fu_ready=0 during reset, all-ones the cycle after release.
